aes_encipher_block: RTL and testbench
=====================================

# aes_encipher_block

Iterative AES encipher datapath: the forward-direction counterpart of the decipher round engine, sharing the same key-memory and core-control interface. On `next` it runs the initial AddRoundKey, then N rounds of SubBytes, ShiftRows, MixColumns and AddRoundKey, with MixColumns omitted in the final round. SubBytes goes through one 32-bit `aes_sbox` instance, one word per cycle. Round keys come from the external key memory, indexed by the `round` output.

## Interface
- `AES_128_BIT_KEY`, 1'h0: keylen encoding for 128-bit keys (10 rounds).
- `AES_256_BIT_KEY`, 1'h1: keylen encoding for 256-bit keys (14 rounds).
- `AES128_ROUNDS`, 4'ha: final round index for 128-bit keys.
- `AES256_ROUNDS`, 4'he: final round index for 256-bit keys.
- `clk` in 1: the single clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `next` in 1: start-encipher strobe; sampled only in IDLE.
- `keylen` in 1: key length select; latched when `next` is accepted.
- `round` out 4: current round index; selects `round_key` in the key memory.
- `round_key` in 128: round key for `round`; must be valid by the cycle after `round` changes.
- `block` in 128: plaintext; sampled in the INIT cycle only.
- `new_block` out 128: state register {w0,w1,w2,w3}; holds the ciphertext once `ready` is high.
- `ready` out 1: high when idle or done.

## Operation
- Registers:
  - state words w0..w3 (32 bits each, per-word write enable);
  - 2-bit sbox word counter `sword_ctr`;
  - 4-bit round counter;
  - `keylen_reg`;
  - `ready_reg`;
  - 2-bit FSM state.
- Byte order: w0 = block[127:96], byte 0 = word[31:24]. Column c is word wc.
- ShiftRows: ws0={w0.b0,w1.b1,w2.b2,w3.b3}, ws1={w1.b0,w2.b1,w3.b2,w0.b3}, ws2={w2.b0,w3.b1,w0.b2,w1.b3}, ws3={w3.b0,w0.b1,w1.b2,w2.b3}.
- MixColumns per word: mb0=2b0^3b1^b2^b3, mb1=b0^2b1^3b2^b3, mb2=b0^b1^2b2^3b3, mb3=3b0^b1^b2^2b3. Here gm2(x) = {x[6:0],0} ^ (8'h1b & {8{x[7]}}).
- FSM states and transitions:
  - IDLE: on `next`, round_ctr←0, keylen_reg←keylen, ready←0, go to INIT. Otherwise hold; registers are unchanged.
  - INIT: state ← `block` ^ `round_key` (key 0), all four words written; round_ctr←1; sword_ctr←0; go to SBOX.
  - SBOX: the aes_sbox input is word[sword_ctr]; that word ← sbox output and no other word is written; sword_ctr++. When sword_ctr==3, go to MAIN.
  - MAIN: sword_ctr←0.
    - If round_ctr < num_rounds: state ← AddRoundKey(MixColumns(ShiftRows(state))), round_ctr++, go to SBOX.
    - Otherwise (final round): state ← AddRoundKey(ShiftRows(state)), ready←1, go to IDLE. round_ctr holds at num_rounds.
- num_rounds is taken from `keylen_reg`, never from live `keylen`.
- Illegal FSM encodings return to IDLE.
- Round counter arithmetic is 4-bit unsigned and never wraps; the maximum value is 14.

## Timing
- Reset values: `new_block`=0, `round`=0, `ready`=1, FSM=IDLE, sword_ctr=0, keylen_reg=0.
- `next` sampled high in IDLE at cycle T gives:
  - INIT at T+1;
  - round r: SBOX at T+5r−3..T+5r, MAIN at T+1+5r;
  - `ready` rises and ciphertext is on `new_block` at T+2+5N: T+52 for AES-128, T+72 for AES-256.
- `ready` falls at T+1.
- Key memory has one cycle to respond: `round` changes at INIT and at each non-final MAIN, and `round_key` is next consumed 5 cycles later.
- `next` while busy (including the final MAIN cycle) is ignored.
- `next` held high continuously restarts immediately: the cycle `ready` rises is IDLE, so a new op is accepted that cycle.
- `keylen` changes mid-operation have no effect.
- `block` changes after INIT have no effect.
- `reset_n` low mid-operation: all registers return to their reset values immediately (asynchronously), and the result is discarded.
- `new_block` holds the result until the next INIT.

## Test plan
- After reset: `ready`=1, `round`=0, `new_block`=0. Apply `next` and check `ready`=0 on the next cycle.
- FIPS-197 AES-128: key 000102…0f, pt 00112233445566778899aabbccddeeff, expanded round keys from the bench key model. Required: ct 69c4e0d86a7b0430d8cdb78070b4c55a, `ready` at T+52.
- FIPS-197 AES-256: key 000102…1f, same pt. Required: ct 8ea2b7ca516745bfeafc49904b496089, `ready` at T+72, `round` sequence 0,1..14.
- SP800-38A ECB-AES128: key 2b7e151628aed2a6abf7158809cf4f3c, pt 6bc1bee22e409f96e93d7e117393172a. Required: ct 3ad77bb40d7a3660a89ecaf32466ef97. Pulse `next` and toggle `keylen` mid-run; the result and latency must be unchanged.
- Back-to-back: hold `next` high across two AES-128 ops with different pt. Both cts must be correct, with the second `ready` 52 cycles after the first.
- Assert `reset_n` low at cycle T+20 of an AES-256 op. Required: immediate reset values, then a fresh op gives the correct ct.

Source files
------------

// File: rtl/aes_encipher_block.sv
// aes_encipher_block: iterative AES encipher round engine, one S-box word per cycle.
// The state is kept as four 32-bit column words, and round keys come from an external key memory.
module aes_encipher_block (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);
    localparam logic       AES_128_BIT_KEY = 1'h0;
    localparam logic       AES_256_BIT_KEY = 1'h1;
    localparam logic [3:0] AES128_ROUNDS   = 4'ha;
    localparam logic [3:0] AES256_ROUNDS   = 4'he;
    localparam logic [1:0] IDLE = 2'd0, INIT = 2'd1, SBOX = 2'd2, MAIN = 2'd3;

    logic [0:3][31:0] w_q, w_d;
    logic [3:0]       w_we;
    logic [1:0]       sword_q, sword_d, fsm_q, fsm_d;
    logic [3:0]       round_q, round_d, num_rounds;
    logic             keylen_q, keylen_d, ready_q, ready_d;
    logic [31:0]      new_sboxw;

    function automatic logic [7:0] gm2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    endfunction

    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = w;
        return {gm2(b0) ^ gm2(b1) ^ b1 ^ b2 ^ b3,
                b0 ^ gm2(b1) ^ gm2(b2) ^ b2 ^ b3,
                b0 ^ b1 ^ gm2(b2) ^ gm2(b3) ^ b3,
                gm2(b0) ^ b0 ^ b1 ^ b2 ^ gm2(b3)};
    endfunction

    function automatic logic [0:3][31:0] shift_rows(input logic [0:3][31:0] s);
        return {s[0][31:24], s[1][23:16], s[2][15:8], s[3][7:0],
                s[1][31:24], s[2][23:16], s[3][15:8], s[0][7:0],
                s[2][31:24], s[3][23:16], s[0][15:8], s[1][7:0],
                s[3][31:24], s[0][23:16], s[1][15:8], s[2][7:0]};
    endfunction

    function automatic logic [0:3][31:0] mix_columns(input logic [0:3][31:0] s);
        return {mixw(s[0]), mixw(s[1]), mixw(s[2]), mixw(s[3])};
    endfunction

    aes_sbox u_sbox (.sboxw_i(w_q[sword_q]), .new_sboxw_o(new_sboxw));

    // Round count follows the key length latched at start, never the live input.
    assign num_rounds = (keylen_q == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;

    always_comb begin
        w_d      = w_q;
        w_we     = 4'h0;
        sword_d  = sword_q;
        round_d  = round_q;
        keylen_d = keylen_q;
        ready_d  = ready_q;
        fsm_d    = fsm_q;
        case (fsm_q)
            IDLE: if (next) begin
                round_d  = 4'd0;
                keylen_d = keylen;
                ready_d  = 1'b0;
                fsm_d    = INIT;
            end
            INIT: begin
                w_d     = block ^ round_key;
                w_we    = 4'hf;
                round_d = 4'd1;
                sword_d = 2'd0;
                fsm_d   = SBOX;
            end
            SBOX: begin
                w_d[sword_q]  = new_sboxw;
                w_we[sword_q] = 1'b1;
                sword_d       = sword_q + 2'd1;
                fsm_d         = (sword_q == 2'd3) ? MAIN : SBOX;
            end
            MAIN: begin
                sword_d = 2'd0;
                w_we    = 4'hf;
                if (round_q < num_rounds) begin
                    w_d     = mix_columns(shift_rows(w_q)) ^ round_key;
                    round_d = round_q + 4'd1;
                    fsm_d   = SBOX;
                end else begin
                    w_d     = shift_rows(w_q) ^ round_key;
                    ready_d = 1'b1;
                    fsm_d   = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_word
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) w_q[g] <= 32'h0;
            else if (w_we[g]) w_q[g] <= w_d[g];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sword_q  <= 2'd0;
            round_q  <= 4'd0;
            keylen_q <= AES_128_BIT_KEY;
            ready_q  <= 1'b1;
            fsm_q    <= IDLE;
        end else begin
            sword_q  <= sword_d;
            round_q  <= round_d;
            keylen_q <= keylen_d;
            ready_q  <= ready_d;
            fsm_q    <= fsm_d;
        end
    end

    assign round     = round_q;
    assign new_block = w_q;
    assign ready     = ready_q;
endmodule

// aes_sbox: four parallel AES S-boxes computed as GF(2^8) inverse plus affine map.
module aes_sbox (
    input  logic [31:0] sboxw_i,
    output logic [31:0] new_sboxw_o
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            p = y[0] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
            y = y >> 1;
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] p, t;
        p = 8'h01;
        t = x;
        for (int i = 0; i < 7; i++) begin
            t = gmul(t, t);
            p = gmul(p, t);
        end
        return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
    endfunction

    assign new_sboxw_o = {sb(sboxw_i[31:24]), sb(sboxw_i[23:16]), sb(sboxw_i[15:8]), sb(sboxw_i[7:0])};
endmodule

// File: tb/tb_aes_encipher_block.sv
// tb_aes_encipher_block: directed FIPS-197 / SP800-38A vectors against a table-driven key-expansion model.
module tb_aes_encipher_block;
    logic         clk = 1'b0;
    logic         reset_n, next, keylen;
    logic [3:0]   round;
    logic [127:0] round_key, block, new_block;
    logic         ready;
    logic [127:0] rk [16];
    int           checks = 0, failures = 0;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K_FIPS128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K_FIPS256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K_SP = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT_SP = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT_SP = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    aes_encipher_block dut (
        .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen), .round(round),
        .round_key(round_key), .block(block), .new_block(new_block), .ready(ready)
    );

    always #5 clk = ~clk;
    assign round_key = rk[round];

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    task automatic load_key(input logic [255:0] key, input logic k256);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nk;
        nk = k256 ? 8 : 4;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < (k256 ? 60 : 44); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % nk == 4) t = subw(t);
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r <= (k256 ? 14 : 10); r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic k256, input logic [127:0] pt,
                         input logic [127:0] exp, input logic wiggle);
        int n, rbad;
        @(negedge clk);
        block = pt; keylen = k256; next = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_ready_fall"}, 128'(ready), 128'(0));
        rbad = (round !== 4'd0) ? 1 : 0;
        next = 1'b0;
        n = 0;
        while (!ready && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (!ready && round !== 4'((n + 4) / 5)) rbad++;
            if (wiggle) begin
                next = (n < 40) ? n[0] : 1'b0;
                keylen = ~keylen;
                block = ~block;
            end
        end
        chk({tag, "_round_seq_errs"}, 128'(rbad), 128'(0));
        chk({tag, "_latency"}, 128'(n), k256 ? 128'(71) : 128'(51));
        chk({tag, "_ct"}, new_block, exp);
        next = 1'b0;
    endtask

    initial begin
        int n;
        reset_n = 1'b0; next = 1'b0; keylen = 1'b0; block = '0;
        load_key(K_FIPS128, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", 128'(ready), 128'(1));
        chk("rst_round", 128'(round), 128'(0));
        chk("rst_new_block", new_block, 128'h0);

        do_op("fips128", 1'b0, PT_FIPS, CT_128, 1'b0);
        load_key(K_FIPS256, 1'b1);
        do_op("fips256", 1'b1, PT_FIPS, CT_256, 1'b0);
        load_key(K_SP, 1'b0);
        do_op("sp_wiggle", 1'b0, PT_SP, CT_SP, 1'b1);

        // Back-to-back: next held high, second key and block presented in the ready cycle.
        load_key(K_FIPS128, 1'b0);
        @(negedge clk);
        block = PT_FIPS; keylen = 1'b0; next = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_lat1", 128'(n), 128'(51));
        chk("b2b_ct1", new_block, CT_128);
        load_key(K_SP, 1'b0);
        block = PT_SP;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 2) next = 1'b0;
        end while (!ready && n < 200);
        chk("b2b_lat2", 128'(n), 128'(52));
        chk("b2b_ct2", new_block, CT_SP);

        // Asynchronous reset in the middle of an AES-256 op.
        load_key(K_FIPS256, 1'b1);
        @(negedge clk);
        block = PT_FIPS; keylen = 1'b1; next = 1'b1;
        @(posedge clk); #1;
        next = 1'b0;
        repeat (19) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 128'(ready), 128'(1));
        chk("mid_rst_round", 128'(round), 128'(0));
        chk("mid_rst_new_block", new_block, 128'h0);
        @(negedge clk) reset_n = 1'b1;
        do_op("post_rst256", 1'b1, PT_FIPS, CT_256, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
